// File: rtl/clksel_pkg.sv
// Shared types and reset constants for the CPU clock-select request logic.
package clksel_pkg;

   // Request FSM: settled on LS/HS, or waiting on the switch in TO_HS/TO_LS.
   typedef enum logic [1:0] {
      LS    = 2'd0,
      TO_HS = 2'd1,
      HS    = 2'd2,
      TO_LS = 2'd3
   } clksel_state_e;

   // The clock switch powers up selecting LS, so the request and the LS
   // feedback synchroniser reset to match it.
   localparam logic RST_HSCLK_SEL = 1'b0;
   localparam logic RST_LS_ACK    = 1'b1;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchroniser with a configurable reset value.
module sync_ff #(
   parameter int unsigned STAGES  = 2,
   parameter logic        RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_b,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain_q;

   // Shift the asynchronous input through the synchroniser chain.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         chain_q <= {STAGES{RST_VAL}};
      end else begin
         chain_q <= {chain_q[STAGES-2:0], d};
      end
   end

   assign q = chain_q[STAGES-1];

endmodule

// File: rtl/clksel_request.sv
// Drives the hsclk_sel request into the CPU clock switch, tracks its
// handshake, holds LS for a minimum host-clock dwell after host-bus accesses
// and flags a switch that never completes.
module clksel_request
   import clksel_pkg::*;
#(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned DWELL_CYCLES   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic hsclk_in,
   input  logic rst_b,
   input  logic lsclk_in,
   input  logic hs_enable,
   input  logic ls_req,
   input  logic hsclk_selected,
   input  logic lsclk_selected,
   output logic hsclk_sel,
   output logic switching,
   output logic on_hs,
   output logic timeout_err
);

   localparam int unsigned DW = $clog2(DWELL_CYCLES + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [DW-1:0] DWELL_LOAD = DW'(DWELL_CYCLES);
   localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYCLES);

   logic hs_ack;
   logic ls_ack;
   logic ls_clk_s;
   logic ls_clk_prev_q;
   logic ls_rise;

   clksel_state_e state_q, state_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [TW-1:0] tmo_inc;
   logic          err_q, err_d;
   logic          hsclk_sel_q, hsclk_sel_d;
   logic          switching_q, switching_d;
   logic          on_hs_q, on_hs_d;

   sync_ff #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b0)
   ) u_sync_hs_ack (
      .clk   (hsclk_in),
      .rst_b (rst_b),
      .d     (hsclk_selected),
      .q     (hs_ack)
   );

   sync_ff #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (RST_LS_ACK)
   ) u_sync_ls_ack (
      .clk   (hsclk_in),
      .rst_b (rst_b),
      .d     (lsclk_selected),
      .q     (ls_ack)
   );

   sync_ff #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (1'b0)
   ) u_sync_ls_clk (
      .clk   (hsclk_in),
      .rst_b (rst_b),
      .d     (lsclk_in),
      .q     (ls_clk_s)
   );

   // One-cycle pulse per synchronised host-clock rising edge.
   assign ls_rise = ls_clk_s & ~ls_clk_prev_q;
   assign tmo_inc = tmo_q + TW'(1);

   // Next state, dwell/timeout counters and registered outputs.
   always_comb begin
      state_d = state_q;
      dwell_d = dwell_q;
      tmo_d   = tmo_q;
      err_d   = err_q;

      unique case (state_q)
         LS: begin
            if (ls_req) begin
               dwell_d = DWELL_LOAD;
            end else if (ls_rise && (dwell_q != '0)) begin
               dwell_d = dwell_q - DW'(1);
            end
            // A request in the same cycle as an expired dwell wins: stay and reload.
            if ((dwell_q == '0) && hs_enable && !ls_req) begin
               state_d = TO_HS;
            end
         end
         TO_HS: begin
            // Never abort a switch in progress; ls_req waits until HS.
            if (hs_ack && !ls_ack) begin
               state_d = HS;
            end
         end
         HS: begin
            if (ls_req || !hs_enable) begin
               state_d = TO_LS;
            end
         end
         TO_LS: begin
            if (ls_ack && !hs_ack) begin
               state_d = LS;
               dwell_d = DWELL_LOAD;
            end
         end
         default: begin
            state_d = LS;
         end
      endcase

      // Count time spent waiting on the switch; expiry is still flagged when
      // the ack lands on the same edge.
      if ((state_q == TO_HS) || (state_q == TO_LS)) begin
         if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_inc;
            if (tmo_inc == TMO_MAX) begin
               err_d = 1'b1;
            end
         end
      end
      if ((state_d != state_q) && ((state_d == TO_HS) || (state_d == TO_LS))) begin
         tmo_d = '0;
      end

      hsclk_sel_d = (state_d == TO_HS) || (state_d == HS);
      switching_d = (state_d == TO_HS) || (state_d == TO_LS);
      on_hs_d     = (state_d == HS);
   end

   // State, counters and output registers.
   always_ff @(posedge hsclk_in or negedge rst_b) begin
      if (!rst_b) begin
         state_q       <= LS;
         dwell_q       <= DWELL_LOAD;
         tmo_q         <= '0;
         err_q         <= 1'b0;
         hsclk_sel_q   <= RST_HSCLK_SEL;
         switching_q   <= 1'b0;
         on_hs_q       <= 1'b0;
         ls_clk_prev_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         dwell_q       <= dwell_d;
         tmo_q         <= tmo_d;
         err_q         <= err_d;
         hsclk_sel_q   <= hsclk_sel_d;
         switching_q   <= switching_d;
         on_hs_q       <= on_hs_d;
         ls_clk_prev_q <= ls_clk_s;
      end
   end

   assign hsclk_sel   = hsclk_sel_q;
   assign switching   = switching_q;
   assign on_hs       = on_hs_q;
   assign timeout_err = err_q;

endmodule

// File: tb/tb_clksel_request.sv
// Directed self-checking bench for clksel_request (SYNC 2, dwell 4, timeout 15).
module tb_clksel_request;

   logic hsclk;
   logic lsclk;
   logic rst_b;
   logic hs_enable;
   logic ls_req;
   logic hsclk_selected;
   logic lsclk_selected;
   logic hsclk_sel;
   logic switching;
   logic on_hs;
   logic timeout_err;

   int vectors     = 0;
   int miscompares = 0;
   int host_edges  = 0;

   clksel_request #(
      .SYNC_STAGES    (2),
      .DWELL_CYCLES   (4),
      .TIMEOUT_CYCLES (15)
   ) dut (
      .hsclk_in       (hsclk),
      .rst_b          (rst_b),
      .lsclk_in       (lsclk),
      .hs_enable      (hs_enable),
      .ls_req         (ls_req),
      .hsclk_selected (hsclk_selected),
      .lsclk_selected (lsclk_selected),
      .hsclk_sel      (hsclk_sel),
      .switching      (switching),
      .on_hs          (on_hs),
      .timeout_err    (timeout_err)
   );

   // HS clock period 10; host clock period 40, edges offset from HS edges.
   initial hsclk = 1'b0;
   always #5 hsclk = ~hsclk;

   initial begin
      lsclk = 1'b0;
      #2;
      forever #20 lsclk = ~lsclk;
   end

   always @(posedge lsclk) host_edges <= host_edges + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic wait_sel(input logic val, input int budget, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge hsclk);
         if (hsclk_sel === val) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Acks to HS at a negedge: two sync stages plus the transition edge.
   task automatic go_hs(input string tag);
      hsclk_selected = 1'b1;
      lsclk_selected = 1'b0;
      repeat (2) @(negedge hsclk);
      vectors++;
      if (on_hs !== 1'b0) begin
         miscompares++;
         $display("FAIL %s_hs_early: on_hs got %b want 0", tag, on_hs);
      end
      @(negedge hsclk);
      vectors++;
      if ({on_hs, switching, hsclk_sel} !== 3'b101) begin
         miscompares++;
         $display("FAIL %s_hs_done: on_hs/switching/hsclk_sel got %b want 101", tag,
                  {on_hs, switching, hsclk_sel});
      end
   endtask

   // Acks to LS, aligned just after a host edge so the dwell count is exact.
   task automatic go_ls(input string tag);
      @(posedge lsclk);
      @(negedge hsclk);
      hsclk_selected = 1'b0;
      lsclk_selected = 1'b1;
      repeat (2) @(negedge hsclk);
      vectors++;
      if (switching !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_ls_early: switching got %b want 1", tag, switching);
      end
      @(negedge hsclk);
      vectors++;
      if ({on_hs, switching, hsclk_sel} !== 3'b000) begin
         miscompares++;
         $display("FAIL %s_ls_done: on_hs/switching/hsclk_sel got %b want 000", tag,
                  {on_hs, switching, hsclk_sel});
      end
   endtask

   task automatic pulse_ls_req();
      ls_req = 1'b1;
      @(negedge hsclk);
      ls_req = 1'b0;
   endtask

   task automatic test_reset();
      rst_b          = 1'b0;
      hs_enable      = 1'b1;
      ls_req         = 1'b0;
      hsclk_selected = 1'b0;
      lsclk_selected = 1'b1;
      @(negedge lsclk);
      vectors++;
      if ({hsclk_sel, switching, on_hs, timeout_err} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_outputs: got %b want 0000",
                  {hsclk_sel, switching, on_hs, timeout_err});
      end
      // Release while the host clock is low so its first rise is a real edge.
      @(posedge hsclk);
      #3 rst_b = 1'b1;
   endtask

   task automatic test_boot();
      int   he0;
      logic ok;
      he0 = host_edges;
      wait_sel(1'b1, 100, ok);
      vectors++;
      if (ok !== 1'b1) begin
         miscompares++;
         $display("FAIL boot_sel_rise: hsclk_sel got %b want 1", hsclk_sel);
      end
      vectors++;
      if (host_edges - he0 !== 4) begin
         miscompares++;
         $display("FAIL boot_dwell: host edges got %0d want 4", host_edges - he0);
      end
      vectors++;
      if ({switching, on_hs} !== 2'b10) begin
         miscompares++;
         $display("FAIL boot_switching: switching/on_hs got %b want 10", {switching, on_hs});
      end
      go_hs("boot");
   endtask

   task automatic test_io_access();
      int   he0;
      logic ok;
      pulse_ls_req();
      vectors++;
      if ({hsclk_sel, switching, on_hs} !== 3'b010) begin
         miscompares++;
         $display("FAIL io_req_latency: hsclk_sel/switching/on_hs got %b want 010",
                  {hsclk_sel, switching, on_hs});
      end
      go_ls("io");
      he0 = host_edges;
      wait_sel(1'b1, 100, ok);
      vectors++;
      if (ok !== 1'b1 || host_edges - he0 !== 4) begin
         miscompares++;
         $display("FAIL io_return_dwell: host edges got %0d want 4 (rise seen %b)",
                  host_edges - he0, ok);
      end
      go_hs("io");
   endtask

   task automatic test_dwell_refresh();
      int   he0;
      logic ok;
      int   early;
      pulse_ls_req();
      go_ls("refresh");
      he0   = host_edges;
      early = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge lsclk);
         repeat (3) @(negedge hsclk);
         if (hsclk_sel !== 1'b0) early++;
         // Request lands just before the next host edge, after this edge's decrement.
         if (i % 3 == 0) begin
            pulse_ls_req();
            he0 = host_edges;
         end
      end
      vectors++;
      if (early !== 0) begin
         miscompares++;
         $display("FAIL refresh_hold: hsclk_sel high on %0d edges want 0", early);
      end
      wait_sel(1'b1, 100, ok);
      vectors++;
      if (ok !== 1'b1 || host_edges - he0 !== 4) begin
         miscompares++;
         $display("FAIL refresh_dwell: host edges got %0d want 4 (rise seen %b)",
                  host_edges - he0, ok);
      end
      go_hs("refresh");
   endtask

   task automatic test_hs_disable();
      int left;
      hs_enable = 1'b0;
      @(negedge hsclk);
      vectors++;
      if ({hsclk_sel, switching} !== 2'b01) begin
         miscompares++;
         $display("FAIL disable_to_ls: hsclk_sel/switching got %b want 01",
                  {hsclk_sel, switching});
      end
      hsclk_selected = 1'b0;
      lsclk_selected = 1'b1;
      repeat (3) @(negedge hsclk);
      vectors++;
      if ({hsclk_sel, switching, on_hs} !== 3'b000) begin
         miscompares++;
         $display("FAIL disable_ls: hsclk_sel/switching/on_hs got %b want 000",
                  {hsclk_sel, switching, on_hs});
      end
      left = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge lsclk);
         repeat (3) @(negedge hsclk);
         if ({hsclk_sel, switching} !== 2'b00) left++;
      end
      vectors++;
      if (left !== 0) begin
         miscompares++;
         $display("FAIL disable_stay_ls: left LS on %0d edges want 0", left);
      end
      // Dwell has long expired, so enabling leaves LS on the very next edge.
      hs_enable = 1'b1;
      @(negedge hsclk);
      vectors++;
      if ({hsclk_sel, switching} !== 2'b11) begin
         miscompares++;
         $display("FAIL enable_to_hs: hsclk_sel/switching got %b want 11",
                  {hsclk_sel, switching});
      end
   endtask

   // Entered with TO_HS observed at this negedge and hs_ack withheld.
   task automatic test_timeout();
      repeat (14) @(negedge hsclk);
      vectors++;
      if (timeout_err !== 1'b0) begin
         miscompares++;
         $display("FAIL timeout_early: timeout_err got %b want 0 at cycle 14", timeout_err);
      end
      @(negedge hsclk);
      vectors++;
      if (timeout_err !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_set: timeout_err got %b want 1 at cycle 15", timeout_err);
      end
      repeat (5) @(negedge hsclk);
      vectors++;
      if ({timeout_err, switching, on_hs} !== 3'b110) begin
         miscompares++;
         $display("FAIL timeout_sticky: err/switching/on_hs got %b want 110",
                  {timeout_err, switching, on_hs});
      end
      go_hs("timeout");
      vectors++;
      if (timeout_err !== 1'b1) begin
         miscompares++;
         $display("FAIL timeout_after_hs: timeout_err got %b want 1", timeout_err);
      end
   endtask

   task automatic test_reset_mid_switch();
      logic ok;
      pulse_ls_req();
      go_ls("midrst");
      wait_sel(1'b1, 100, ok);
      vectors++;
      if (ok !== 1'b1 || switching !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_to_hs: rise seen %b switching %b want 1 1", ok, switching);
      end
      // Assert reset between edges and look before the next rising edge.
      #2 rst_b = 1'b0;
      #1;
      vectors++;
      if ({hsclk_sel, switching, on_hs, timeout_err} !== 4'b0000) begin
         miscompares++;
         $display("FAIL midrst_async: got %b want 0000",
                  {hsclk_sel, switching, on_hs, timeout_err});
      end
   endtask

   initial begin
      test_reset();
      test_boot();
      test_io_access();
      test_dwell_refresh();
      test_hs_disable();
      test_timeout();
      test_reset_mid_switch();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
